// File: rtl/reg_bank_reader.sv
// Sequential read-out engine for an 8 x 16-bit register bank: walks an inclusive,
// wrapping register range and streams each value on a valid/ready interface.
module reg_bank_reader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              snoop_wr_en,
  input  logic [ADDR_W-1:0] snoop_wr_reg,
  input  logic [DATA_W-1:0] snoop_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_reg,
  output logic              out_last
);

  typedef enum logic [1:0] {StIdle, StRead, StHold, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_first, w_first_d;
  logic [ADDR_W-1:0]   r_last, w_last_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [DATA_W-1:0]   r_out_data, w_out_data_d;
  logic [ADDR_W-1:0]   r_out_reg, w_out_reg_d;
  logic                r_out_last, w_out_last_d;
  logic [DATA_W-1:0]   w_value;

  // A write landing on the register being read this cycle wins over the stale bank data.
  assign w_value = (snoop_wr_en && (snoop_wr_reg == r_addr)) ? snoop_wr_data : rd_data;

  always_comb begin
    w_state_d    = r_state;
    w_first_d    = r_first;
    w_last_d     = r_last;
    w_addr_d     = r_addr;
    w_out_data_d = r_out_data;
    w_out_reg_d  = r_out_reg;
    w_out_last_d = r_out_last;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_first_d = first_reg;
          w_last_d  = last_reg;
          w_addr_d  = first_reg;
          w_state_d = StRead;
        end
      end
      StRead: begin
        w_out_data_d = w_value;
        w_out_reg_d  = r_addr;
        w_out_last_d = (r_addr == r_last);
        w_state_d    = StHold;
      end
      StHold: begin
        if (out_ready) begin
          if (r_out_last) begin
            w_state_d = StDone;
          end else begin
            // Natural ADDR_W-bit overflow gives the 7 -> 0 wrap.
            w_addr_d  = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            w_state_d = StRead;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_first    <= '0;
      r_last     <= '0;
      r_addr     <= '0;
      r_out_data <= '0;
      r_out_reg  <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_first    <= w_first_d;
      r_last     <= w_last_d;
      r_addr     <= w_addr_d;
      r_out_data <= w_out_data_d;
      r_out_reg  <= w_out_reg_d;
      r_out_last <= w_out_last_d;
    end
  end

  assign busy      = (r_state == StRead) || (r_state == StHold);
  assign done      = (r_state == StDone);
  assign out_valid = (r_state == StHold);
  assign rd_reg    = r_addr;
  assign out_data  = r_out_data;
  assign out_reg   = r_out_reg;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader: behavioural bank model, sweeps with stalls,
// write forwarding, asynchronous reset mid-sweep and ignored start requests.
module tb_reg_bank_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  first_reg = '0;
  logic [2:0]  last_reg = '0;
  logic        busy;
  logic        done;
  logic [2:0]  rd_reg;
  logic [15:0] rd_data;
  logic        snoop_wr_en = 1'b0;
  logic [2:0]  snoop_wr_reg = '0;
  logic [15:0] snoop_wr_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_reg;
  logic        out_last;

  logic [15:0] bank [8];
  int total = 0;
  int bad = 0;

  reg_bank_reader #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .first_reg    (first_reg),
    .last_reg     (last_reg),
    .busy         (busy),
    .done         (done),
    .rd_reg       (rd_reg),
    .rd_data      (rd_data),
    .snoop_wr_en  (snoop_wr_en),
    .snoop_wr_reg (snoop_wr_reg),
    .snoop_wr_data(snoop_wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_reg      (out_reg),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  // Register bank model: combinational read, clocked write on the snooped port.
  assign rd_data = bank[rd_reg];
  always @(posedge clk) begin
    if (snoop_wr_en) bank[snoop_wr_reg] <= snoop_wr_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pre(input int r);
    return 16'((r + 1) * 4);
  endfunction

  task automatic load_bank();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      snoop_wr_en   = 1'b1;
      snoop_wr_reg  = 3'(i);
      snoop_wr_data = pre(i);
    end
    @(negedge clk);
    snoop_wr_en = 1'b0;
  endtask

  // One sweep f..l; optional ready stall, forwarded write, or stray start on given beats.
  task automatic do_sweep(input int f, input int l, input int stall_beat, input int stall_cycles,
                          input int snoop_beat, input logic [15:0] snoop_val, input int poke_beat);
    int n;
    int k;
    int stall;
    int guard;
    logic [2:0]  er;
    logic [15:0] ev;
    n     = ((l - f) & 7) + 1;
    k     = 0;
    stall = stall_cycles;
    guard = 0;
    @(negedge clk);
    start     = 1'b1;
    first_reg = 3'(f);
    last_reg  = 3'(l);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("valid_latency", 32'(out_valid), 32'd0);
    while (k < n && guard < 200) begin
      guard++;
      er = 3'((f + k) & 7);
      ev = (k == snoop_beat) ? snoop_val : pre(int'(er));
      if (!out_valid) begin
        check_eq("rd_reg_read", 32'(rd_reg), 32'(er));
        if (k == snoop_beat) begin
          snoop_wr_en   = 1'b1;
          snoop_wr_reg  = er;
          snoop_wr_data = snoop_val;
        end
      end else begin
        check_eq("out_reg", 32'(out_reg), 32'(er));
        check_eq("out_data", 32'(out_data), 32'(ev));
        check_eq("out_last", 32'(out_last), 32'(k == n - 1));
        check_eq("rd_reg_hold", 32'(rd_reg), 32'(er));
        check_eq("busy_hold", 32'(busy), 32'd1);
        if (k == stall_beat && stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          if (k == poke_beat) begin
            start     = 1'b1;
            first_reg = 3'd2;
            last_reg  = 3'd2;
          end
          k++;
        end
      end
      @(negedge clk);
      snoop_wr_en = 1'b0;
      start       = 1'b0;
    end
    check_eq("beat_count", 32'(k), 32'(n));
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_in_done", 32'(busy), 32'd0);
    check_eq("valid_in_done", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_reg", 32'(out_reg), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_rd_reg", 32'(rd_reg), 32'd0);
    load_bank();
    @(negedge clk);
    rst = 1'b1;

    do_sweep(0, 7, -1, 0, -1, 16'h0, -1);
    do_sweep(6, 1, -1, 0, -1, 16'h0, -1);
    do_sweep(0, 3, 1, 3, -1, 16'h0, -1);
    do_sweep(2, 4, -1, 0, 1, 16'hBEEF, -1);
    load_bank();

    // Reset while the third beat is pending: two beats accepted at fixed 2-cycle pace.
    @(negedge clk);
    start     = 1'b1;
    first_reg = 3'd0;
    last_reg  = 3'd7;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    check_eq("pre_rst_reg", 32'(out_reg), 32'd2);
    #1 rst = 1'b0;
    #1;
    check_eq("async_valid", 32'(out_valid), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_data", 32'(out_data), 32'd0);
    check_eq("async_rd_reg", 32'(rd_reg), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_done_in_rst", 32'(done), 32'd0);
    end
    rst = 1'b1;
    do_sweep(5, 5, -1, 0, -1, 16'h0, -1);

    do_sweep(0, 7, -1, 0, -1, 16'h0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
